// File: rtl/ecc_pkg.sv
// Shared definitions for the 185-bit ECC read path: widths, status-bit indices
// and the default counter ceiling.
package ecc_pkg;
  localparam int ECC_DATA_W = 185;
  localparam int ECC_PAR_W  = 9;
  localparam int ECC_CNT_W  = 16;

  localparam int ST_SBIT  = 0;
  localparam int ST_DBIT  = 1;
  localparam int ST_FAULT = 2;

  localparam logic [ECC_CNT_W-1:0] CNT_MAX = {ECC_CNT_W{1'b1}};
endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter. A clear and an increment in the same cycle leave
// the count at 1, so an event coincident with a clear is never lost.
module ecc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic at_max;
  assign at_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= inc ? W'(1) : '0;
    else if (inc && !at_max)
      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/ecc_185_err_mon.sv
// ECC error monitor: one-deep registered read word with valid/ready, sticky
// error flags, saturating counters, first-error capture and a level interrupt.
module ecc_185_err_mon
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = ECC_DATA_W,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ECC_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic                  in_ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_uncorr,
  input  logic [2:0]            irq_en,
  input  logic                  clr,
  output logic [2:0]            sticky,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  cap_vld,
  output logic [ADDR_WIDTH-1:0] cap_addr,
  output logic [2:0]            cap_type,
  output logic                  irq
);
  logic       acc;
  logic [2:0] ev;
  logic       any_ev;

  assign in_rdy = ~out_vld | out_rdy;
  assign acc    = in_vld & in_rdy;

  // Status only counts when the word is actually taken.
  always_comb begin
    ev           = '0;
    ev[ST_SBIT]  = acc & in_sbit_err;
    ev[ST_DBIT]  = acc & in_dbit_err;
    ev[ST_FAULT] = acc & in_ecc_fault;
  end
  assign any_ev = |ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_uncorr <= 1'b0;
    end else if (acc) begin
      out_vld    <= 1'b1;
      out_data   <= in_data;
      out_uncorr <= in_dbit_err | in_ecc_fault;
    end else if (out_rdy) begin
      out_vld    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky <= '0;
    else if (clr)
      sticky <= ev;
    else
      sticky <= sticky | ev;
  end

  // A clear re-arms the capture; an event in the same cycle becomes the new first error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld  <= 1'b0;
      cap_addr <= '0;
      cap_type <= '0;
    end else if (any_ev && (clr || !cap_vld)) begin
      cap_vld  <= 1'b1;
      cap_addr <= in_addr;
      cap_type <= ev;
    end else if (clr) begin
      cap_vld  <= 1'b0;
      cap_addr <= '0;
      cap_type <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= |(sticky & irq_en);
  end

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_sbit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (ev[ST_SBIT]),
    .cnt (sbit_cnt)
  );

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_dbit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (ev[ST_DBIT]),
    .cnt (dbit_cnt)
  );

  ecc_sat_cnt #(.W(CNT_WIDTH)) u_fault_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (ev[ST_FAULT]),
    .cnt (fault_cnt)
  );
endmodule

// File: tb/tb_ecc_185_err_mon.sv
// Directed bench for ecc_185_err_mon: handshake, logging, saturation, clear and reset.
module tb_ecc_185_err_mon;
  localparam int DW = 185;
  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_sbit_err;
  logic          in_dbit_err;
  logic          in_ecc_fault;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_uncorr;
  logic [2:0]    irq_en;
  logic          clr;
  logic [2:0]    sticky;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic [CW-1:0] fault_cnt;
  logic          cap_vld;
  logic [AW-1:0] cap_addr;
  logic [2:0]    cap_type;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_185_err_mon dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_sbit_err  (in_sbit_err),
    .in_dbit_err  (in_dbit_err),
    .in_ecc_fault (in_ecc_fault),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .out_uncorr   (out_uncorr),
    .irq_en       (irq_en),
    .clr          (clr),
    .sticky       (sticky),
    .sbit_cnt     (sbit_cnt),
    .dbit_cnt     (dbit_cnt),
    .fault_cnt    (fault_cnt),
    .cap_vld      (cap_vld),
    .cap_addr     (cap_addr),
    .cap_type     (cap_type),
    .irq          (irq)
  );

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return {1'b1, {23{a ^ 8'h5A}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [2:0] st);
    in_vld       = v;
    in_addr      = a;
    in_data      = mk_data(a);
    in_sbit_err  = st[0];
    in_dbit_err  = st[1];
    in_ecc_fault = st[2];
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; in_addr = '0; in_data = '0;
    in_sbit_err = 1'b0; in_dbit_err = 1'b0; in_ecc_fault = 1'b0;
    out_rdy = 1'b1; irq_en = 3'b000; clr = 1'b0;
    tick(); tick();
    n_checks++;
    if ({out_vld, out_uncorr, sticky, cap_vld, irq} !== 7'b0 || out_data !== '0 ||
        sbit_cnt !== '0 || dbit_cnt !== '0 || fault_cnt !== '0 || cap_addr !== '0 || cap_type !== '0) begin
      $display("FAIL reset_state: out_vld=%b sticky=%b cap_vld=%b irq=%b cnts=%h/%h/%h expected all zero",
               out_vld, sticky, cap_vld, irq, sbit_cnt, dbit_cnt, fault_cnt);
      n_fail++;
    end
    n_checks++;
    if (in_rdy !== 1'b1) begin
      $display("FAIL reset_in_rdy: got %b expected 1", in_rdy);
      n_fail++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_words();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 3'b000);
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== mk_data(AW'(i)) || out_uncorr !== 1'b0) begin
        $display("FAIL clean_word_%0d: vld=%b uncorr=%b data=%h expected vld=1 uncorr=0 data=%h",
                 i, out_vld, out_uncorr, out_data, mk_data(AW'(i)));
        n_fail++;
      end
    end
    drive(1'b0, 8'h00, 3'b000);
    tick();
    n_checks++;
    if (out_vld !== 1'b0 || sbit_cnt !== '0 || dbit_cnt !== '0 || fault_cnt !== '0 ||
        sticky !== 3'b000 || irq !== 1'b0 || cap_vld !== 1'b0) begin
      $display("FAIL clean_no_log: vld=%b sticky=%b cnts=%h/%h/%h irq=%b cap_vld=%b expected all 0",
               out_vld, sticky, sbit_cnt, dbit_cnt, fault_cnt, irq, cap_vld);
      n_fail++;
    end
  endtask

  task automatic test_sbit();
    irq_en = 3'b001;
    drive(1'b1, 8'h12, 3'b001);
    tick();
    drive(1'b0, 8'h00, 3'b000);
    n_checks++;
    if (sticky !== 3'b001 || sbit_cnt !== 16'd1 || cap_vld !== 1'b1 ||
        cap_addr !== 8'h12 || cap_type !== 3'b001 || out_uncorr !== 1'b0) begin
      $display("FAIL sbit_log: sticky=%b cnt=%h cap=%b/%h/%b uncorr=%b expected 001/0001/1/12/001/0",
               sticky, sbit_cnt, cap_vld, cap_addr, cap_type, out_uncorr);
      n_fail++;
    end
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL sbit_irq_early: got %b expected 0", irq);
      n_fail++;
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      $display("FAIL sbit_irq: got %b expected 1", irq);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    out_rdy = 1'b0;
    drive(1'b1, 8'h30, 3'b000);
    tick();
    drive(1'b1, 8'h31, 3'b000);
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== mk_data(8'h30) || in_rdy !== 1'b0) begin
      $display("FAIL stall_accept: vld=%b in_rdy=%b data=%h expected 1/0/%h",
               out_vld, in_rdy, out_data, mk_data(8'h30));
      n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_data !== mk_data(8'h30) || in_rdy !== 1'b0) begin
        $display("FAIL stall_hold_%0d: vld=%b in_rdy=%b data=%h expected 1/0/%h",
                 i, out_vld, in_rdy, out_data, mk_data(8'h30));
        n_fail++;
      end
    end
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) begin
      $display("FAIL stall_rdy_comb: got %b expected 1", in_rdy);
      n_fail++;
    end
    tick();
    drive(1'b0, 8'h00, 3'b000);
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== mk_data(8'h31)) begin
      $display("FAIL stall_next: vld=%b data=%h expected 1/%h", out_vld, out_data, mk_data(8'h31));
      n_fail++;
    end
    tick();
    n_checks++;
    if (out_vld !== 1'b0) begin
      $display("FAIL stall_drain: vld=%b expected 0", out_vld);
      n_fail++;
    end
  endtask

  task automatic test_saturate();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (sbit_cnt !== '0 || sticky !== 3'b000 || cap_vld !== 1'b0) begin
      $display("FAIL sat_clr: cnt=%h sticky=%b cap_vld=%b expected 0", sbit_cnt, sticky, cap_vld);
      n_fail++;
    end
    out_rdy = 1'b1;
    drive(1'b1, 8'h40, 3'b001);
    for (int i = 0; i < 16'hFFFE; i++) tick();
    n_checks++;
    if (sbit_cnt !== 16'hFFFE) begin
      $display("FAIL sat_preload: got %h expected fffe", sbit_cnt);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (sbit_cnt !== 16'hFFFF) begin
        $display("FAIL sat_hold_%0d: got %h expected ffff", i, sbit_cnt);
        n_fail++;
      end
    end
    drive(1'b0, 8'h00, 3'b000);
    tick();
    n_checks++;
    if (dbit_cnt !== '0 || fault_cnt !== '0 || cap_addr !== 8'h40) begin
      $display("FAIL sat_others: dbit=%h fault=%h cap_addr=%h expected 0/0/40", dbit_cnt, fault_cnt, cap_addr);
      n_fail++;
    end
  endtask

  task automatic test_dbit_fault();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b1, 8'h05, 3'b010);
    tick();
    n_checks++;
    if (out_uncorr !== 1'b1) begin
      $display("FAIL dbit_uncorr: got %b expected 1", out_uncorr);
      n_fail++;
    end
    drive(1'b1, 8'h06, 3'b100);
    tick();
    n_checks++;
    if (out_uncorr !== 1'b1) begin
      $display("FAIL fault_uncorr: got %b expected 1", out_uncorr);
      n_fail++;
    end
    drive(1'b0, 8'h00, 3'b000);
    tick();
    n_checks++;
    if (cap_addr !== 8'h05 || cap_type !== 3'b010 || sticky !== 3'b110 ||
        dbit_cnt !== 16'd1 || fault_cnt !== 16'd1 || sbit_cnt !== 16'd0) begin
      $display("FAIL dbit_fault_log: cap=%h/%b sticky=%b cnts=%h/%h/%h expected 05/010/110 0000/0001/0001",
               cap_addr, cap_type, sticky, sbit_cnt, dbit_cnt, fault_cnt);
      n_fail++;
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL masked_irq: got %b expected 0", irq);
      n_fail++;
    end
  endtask

  task automatic test_clr_event();
    clr = 1'b1;
    drive(1'b1, 8'h20, 3'b001);
    tick();
    clr = 1'b0;
    drive(1'b0, 8'h00, 3'b000);
    n_checks++;
    if (sbit_cnt !== 16'd1 || dbit_cnt !== 16'd0 || fault_cnt !== 16'd0 || sticky !== 3'b001 ||
        cap_vld !== 1'b1 || cap_addr !== 8'h20 || cap_type !== 3'b001) begin
      $display("FAIL clr_event: cnts=%h/%h/%h sticky=%b cap=%b/%h/%b expected 0001/0000/0000 001 1/20/001",
               sbit_cnt, dbit_cnt, fault_cnt, sticky, cap_vld, cap_addr, cap_type);
      n_fail++;
    end
    n_checks++;
    if (out_vld !== 1'b1 || out_data !== mk_data(8'h20)) begin
      $display("FAIL clr_datapath: vld=%b data=%h expected 1/%h", out_vld, out_data, mk_data(8'h20));
      n_fail++;
    end
  endtask

  task automatic test_rst_mid();
    out_rdy = 1'b0;
    drive(1'b1, 8'h77, 3'b000);
    tick();
    drive(1'b0, 8'h00, 3'b000);
    n_checks++;
    if (out_vld !== 1'b1) begin
      $display("FAIL rst_mid_pre: vld=%b expected 1", out_vld);
      n_fail++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_vld !== 1'b0 || out_data !== '0 || sticky !== 3'b000 || sbit_cnt !== '0 || cap_vld !== 1'b0) begin
      $display("FAIL rst_mid: vld=%b sticky=%b cnt=%h cap_vld=%b expected all 0",
               out_vld, sticky, sbit_cnt, cap_vld);
      n_fail++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_words();
    test_sbit();
    test_stall();
    test_saturate();
    test_dbit_fault();
    test_clr_event();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
